// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: the core's fetch and data ports plus the 8-bit external memory bus.
interface mem_ctrl_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        me_req_i;
    logic        me_we_i;
    logic [31:0] me_addr_i;
    logic [31:0] me_wdata_i;
    logic [3:0]  me_sel_i;
    logic [31:0] me_rdata_o;
    logic        me_done_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic [7:0]  mem_din_i;

    // Core plus external memory side.
    modport master (
        output if_req_i, if_addr_i, me_req_i, me_we_i, me_addr_i, me_wdata_i, me_sel_i,
        output mem_din_i,
        input  if_data_o, if_done_o, me_rdata_o, me_done_o, mem_a_o, mem_dout_o, mem_wr_o
    );

    // Controller side.
    modport slave (
        input  if_req_i, if_addr_i, me_req_i, me_we_i, me_addr_i, me_wdata_i, me_sel_i,
        input  mem_din_i,
        output if_data_o, if_done_o, me_rdata_o, me_done_o, mem_a_o, mem_dout_o, mem_wr_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 32-bit fetch/data accesses into byte transfers on an 8-bit bus.
// ME has priority over IF; read data returns one cycle after its address.
module mem_ctrl (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StIfRd, StMeRd, StMeWr, StDone} state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;    // index of the byte address currently driven
    logic [2:0]  n_q;      // transfer length in bytes
    logic        tail_q;   // all addresses issued, last read byte arriving
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;    // read word under assembly
    logic [3:0]  sel_q;

    logic [3:0]  me_sel_eff;
    logic [2:0]  me_len;
    logic [1:0]  cnt_nxt;
    logic [1:0]  rd_idx;
    logic [31:0] buf_d;
    logic        last_addr;
    logic        if_abort;

    // Decode ME request: empty select means full word; length runs to the highest lane.
    always_comb begin
        me_sel_eff = (bus.me_sel_i == 4'b0000) ? 4'b1111 : bus.me_sel_i;
        me_len     = 3'd1;
        for (int k = 1; k < 4; k++) begin
            if (me_sel_eff[k]) me_len = 3'(k + 1);
        end
    end

    // Byte arriving now belongs to the address driven one cycle earlier.
    always_comb begin
        cnt_nxt   = cnt_q + 2'd1;
        last_addr = ({1'b0, cnt_q} == n_q - 3'd1);
        rd_idx    = tail_q ? 2'(n_q - 3'd1) : cnt_q - 2'd1;
        buf_d     = buf_q;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == rd_idx) buf_d[8*k +: 8] = bus.mem_din_i;
        end
        if_abort  = !bus.if_req_i || (bus.if_addr_i != base_q);
    end

    // Access FSM with all bus and port outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= 2'd0;
            n_q            <= 3'd0;
            tail_q         <= 1'b0;
            base_q         <= 32'd0;
            wdata_q        <= 32'd0;
            buf_q          <= 32'd0;
            sel_q          <= 4'd0;
            bus.if_data_o  <= 32'd0;
            bus.if_done_o  <= 1'b0;
            bus.me_rdata_o <= 32'd0;
            bus.me_done_o  <= 1'b0;
            bus.mem_a_o    <= 32'd0;
            bus.mem_dout_o <= 8'd0;
            bus.mem_wr_o   <= 1'b0;
        end else begin
            bus.if_done_o <= 1'b0;
            bus.me_done_o <= 1'b0;
            bus.mem_wr_o  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q  <= 2'd0;
                    tail_q <= 1'b0;
                    buf_q  <= 32'd0;
                    if (bus.me_req_i) begin
                        base_q      <= bus.me_addr_i;
                        wdata_q     <= bus.me_wdata_i;
                        sel_q       <= me_sel_eff;
                        n_q         <= me_len;
                        bus.mem_a_o <= bus.me_addr_i;
                        if (bus.me_we_i) begin
                            bus.mem_dout_o <= bus.me_wdata_i[7:0];
                            bus.mem_wr_o   <= me_sel_eff[0];
                            state_q        <= StMeWr;
                        end else begin
                            state_q <= StMeRd;
                        end
                    end else if (bus.if_req_i) begin
                        base_q      <= bus.if_addr_i;
                        sel_q       <= 4'b1111;
                        n_q         <= 3'd4;
                        bus.mem_a_o <= bus.if_addr_i;
                        state_q     <= StIfRd;
                    end
                end
                StIfRd, StMeRd: begin
                    // A dropped or redirected fetch is abandoned without a done pulse.
                    if (state_q == StIfRd && if_abort) begin
                        state_q <= StIdle;
                    end else begin
                        if (tail_q || cnt_q != 2'd0) buf_q <= buf_d;
                        if (tail_q) begin
                            if (state_q == StIfRd) begin
                                bus.if_data_o <= buf_d;
                                bus.if_done_o <= 1'b1;
                            end else begin
                                bus.me_rdata_o <= buf_d;
                                bus.me_done_o  <= 1'b1;
                            end
                            state_q <= StDone;
                        end else if (last_addr) begin
                            tail_q <= 1'b1;
                        end else begin
                            cnt_q       <= cnt_nxt;
                            bus.mem_a_o <= base_q + {30'd0, cnt_nxt};
                        end
                    end
                end
                StMeWr: begin
                    if (last_addr) begin
                        bus.me_done_o <= 1'b1;
                        state_q       <= StDone;
                    end else begin
                        cnt_q          <= cnt_nxt;
                        bus.mem_a_o    <= base_q + {30'd0, cnt_nxt};
                        bus.mem_dout_o <= wdata_q[{cnt_nxt, 3'b000} +: 8];
                        bus.mem_wr_o   <= sel_q[cnt_nxt];
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-level memory model.
module tb_mem_ctrl;
    logic clk;
    logic rst;
    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  env_mem [logic [31:0]];  // memory the DUT actually talks to
    logic [7:0]  ref_mem [logic [31:0]];  // expected memory contents
    logic [31:0] prev_a = 32'd0;
    logic [31:0] last_if = 32'd0;
    logic [31:0] last_me = 32'd0;
    logic [31:0] tr_a  [0:31];
    logic        tr_wr [0:31];
    logic [7:0]  tr_do [0:31];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // External memory: stores strobed bytes, returns data for last cycle's address.
    always @(negedge clk) begin
        if (bus.mem_wr_o) env_mem[bus.mem_a_o] = bus.mem_dout_o;
        bus.mem_din_i = env_rd(prev_a);
        prev_a = bus.mem_a_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
        env_mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_data"}, bus.if_data_o, 32'd0);
        chk({tag, "_if_done"}, {31'd0, bus.if_done_o}, 32'd0);
        chk({tag, "_me_rdata"}, bus.me_rdata_o, 32'd0);
        chk({tag, "_me_done"}, {31'd0, bus.me_done_o}, 32'd0);
        chk({tag, "_mem_a"}, bus.mem_a_o, 32'd0);
        chk({tag, "_mem_dout"}, {24'd0, bus.mem_dout_o}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, bus.mem_wr_o}, 32'd0);
    endtask

    // Step cycles until the selected port's done pulse; records the bus each cycle.
    task automatic wait_done(input bit is_if, input int limit, output int got, output bit other);
        got   = -1;
        other = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            tr_a[i]  = bus.mem_a_o;
            tr_wr[i] = bus.mem_wr_o;
            tr_do[i] = bus.mem_dout_o;
            if (is_if ? bus.me_done_o : bus.if_done_o) other = 1'b1;
            if (is_if ? bus.if_done_o : bus.me_done_o) begin
                got = i;
                break;
            end
        end
    endtask

    // One complete access, issued in the current (idle) cycle and checked end to end.
    task automatic run_op(input bit is_if, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
        logic [3:0]  s;
        logic [31:0] exp;
        logic        wr_any;
        int          n;
        int          lat;
        int          got;
        bit          other;
        bit          is_wr;
        is_wr = !is_if && we;
        s = (is_if || sel == 4'd0) ? 4'hF : sel;
        n = 0;
        for (int k = 0; k < 4; k++) if (s[k]) n = k + 1;
        lat = is_wr ? n + 1 : n + 2;
        exp = 32'd0;
        for (int k = 0; k < n; k++) exp |= {24'd0, ref_rd(addr + 32'(k))} << (8 * k);
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.me_req_i   = 1'b1;
            bus.me_we_i    = we;
            bus.me_addr_i  = addr;
            bus.me_wdata_i = wdata;
            bus.me_sel_i   = sel;
        end
        wait_done(is_if, 16, got, other);
        chk("latency", 32'(got), 32'(lat));
        chk("other_done", {31'd0, other}, 32'd0);
        if (is_if) begin
            chk("if_data", bus.if_data_o, exp);
            chk("me_hold", bus.me_rdata_o, last_me);
            last_if = exp;
        end else if (!we) begin
            chk("me_rdata", bus.me_rdata_o, exp);
            chk("if_hold", bus.if_data_o, last_if);
            last_me = exp;
        end else begin
            chk("wr_rdata_hold", bus.me_rdata_o, last_me);
        end
        for (int k = 0; k < n; k++) chk("addr", tr_a[1+k], addr + 32'(k));
        if (is_wr) begin
            for (int k = 0; k < n; k++) begin
                chk("wr_strobe", {31'd0, tr_wr[1+k]}, {31'd0, s[k]});
                if (s[k]) begin
                    chk("wr_byte", {24'd0, tr_do[1+k]}, {24'd0, wdata[8*k +: 8]});
                    ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
                end
            end
            chk("wr_done_idle", {31'd0, tr_wr[n+1]}, 32'd0);
        end else begin
            wr_any = 1'b0;
            for (int i = 1; i <= lat; i++) wr_any |= tr_wr[i];
            chk("rd_no_wr", {31'd0, wr_any}, 32'd0);
            chk("addr_hold", tr_a[lat], addr + 32'(n - 1));
        end
        bus.if_req_i = 1'b0;
        bus.me_req_i = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {30'd0, bus.if_done_o, bus.me_done_o}, 32'd0);
    endtask

    initial begin
        int          got;
        bit          other;
        bit          seen;
        logic [31:0] exp;
        logic [31:0] addr;
        int          kind;

        rst = 1'b1;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'd0;
        bus.me_req_i   = 1'b0;
        bus.me_we_i    = 1'b0;
        bus.me_addr_i  = 32'd0;
        bus.me_wdata_i = 32'd0;
        bus.me_sel_i   = 4'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Word read.
        set_byte(32'h100, 8'h11);
        set_byte(32'h101, 8'h22);
        set_byte(32'h102, 8'h33);
        set_byte(32'h103, 8'h44);
        run_op(1'b0, 1'b0, 32'h100, 32'd0, 4'hF);
        chk("lw_word", bus.me_rdata_o, 32'h4433_2211);

        // Half-word write.
        run_op(1'b0, 1'b1, 32'h200, 32'hAABB_CCDD, 4'b0011);
        chk("sh_byte0", {24'd0, env_rd(32'h200)}, 32'h0000_00DD);
        chk("sh_byte1", {24'd0, env_rd(32'h201)}, 32'h0000_00CC);
        chk("sh_byte2_untouched", {24'd0, env_rd(32'h202)}, {24'd0, init_byte(32'h202)});

        // Simultaneous requests: ME first, one idle cycle, then the fetch.
        exp = 32'd0;
        for (int k = 0; k < 4; k++) exp |= {24'd0, ref_rd(32'h300 + 32'(k))} << (8 * k);
        bus.me_req_i  = 1'b1;
        bus.me_we_i   = 1'b0;
        bus.me_addr_i = 32'h300;
        bus.me_sel_i  = 4'hF;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h400;
        wait_done(1'b0, 16, got, other);
        chk("arb_me_latency", 32'(got), 32'd6);
        chk("arb_if_not_early", {31'd0, other}, 32'd0);
        chk("arb_me_data", bus.me_rdata_o, exp);
        last_me = exp;
        bus.me_req_i = 1'b0;
        exp = 32'd0;
        for (int k = 0; k < 4; k++) exp |= {24'd0, ref_rd(32'h400 + 32'(k))} << (8 * k);
        wait_done(1'b1, 16, got, other);
        chk("arb_if_after_gap", 32'(got), 32'd7);
        chk("arb_me_pulse_width", {31'd0, other}, 32'd0);
        chk("arb_if_data", bus.if_data_o, exp);
        last_if = exp;
        bus.if_req_i = 1'b0;
        @(negedge clk);
        chk("arb_if_pulse_width", {31'd0, bus.if_done_o}, 32'd0);

        // Fetch redirected two cycles in.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        bus.if_addr_i = 32'h40;
        exp = 32'd0;
        for (int k = 0; k < 4; k++) exp |= {24'd0, ref_rd(32'h40 + 32'(k))} << (8 * k);
        wait_done(1'b1, 16, got, other);
        chk("abort_latency", 32'(got), 32'd7);
        chk("abort_data", bus.if_data_o, exp);
        last_if = exp;
        bus.if_req_i = 1'b0;
        @(negedge clk);

        // Byte read at the top of the address space, then a wrapping fetch.
        set_byte(32'hFFFF_FFFF, 8'h80);
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 4'b0001);
        chk("lb_wrap", bus.me_rdata_o, 32'h0000_0080);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0, 4'hF);

        // Reset two cycles into a word write.
        bus.me_req_i   = 1'b1;
        bus.me_we_i    = 1'b1;
        bus.me_addr_i  = 32'h500;
        bus.me_wdata_i = 32'h1234_5678;
        bus.me_sel_i   = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        bus.me_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_if = 32'd0;
        last_me = 32'd0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.me_done_o || bus.if_done_o || bus.mem_wr_o) seen = 1'b1;
        end
        chk("no_done_after_reset", {31'd0, seen}, 32'd0);
        run_op(1'b0, 1'b0, 32'h100, 32'd0, 4'hF);
        chk("accept_after_reset", bus.me_rdata_o, 32'h4433_2211);

        // Random mix against the memory model.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else addr = 32'h1000 + 32'($urandom_range(0, 63));
            run_op(kind == 0, kind == 2, addr, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
